// File: rtl/alarme_votacao_param.sv
// alarme_votacao_param: debounced N-sensor majority vote alarm with arm/disarm FSM, entry delay and trigger memory
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   sensores   : raw active-high sensor lines
//   armar      : arm request (ignored unless disarmed and no vote)
//   desarmar   : disarm request, wins over everything but rst
//   armado     : high in ARMADO, ENTRADA, DISPARADO
//   pre_alarme : high in ENTRADA (entry delay running)
//   alarme     : high in DISPARADO (latched until disarm)
//   contagem   : registered popcount of the filtered sensors
//   memoria    : sensors that contributed to the last trigger
module alarme_votacao_param #(
    parameter int N_SENSORES     = 3,
    parameter int LIMIAR         = 2,
    parameter int DEBOUNCE       = 4,
    parameter int ATRASO_ENTRADA = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_SENSORES-1:0]           sensores,
    input  logic                            armar,
    input  logic                            desarmar,
    output logic                            armado,
    output logic                            pre_alarme,
    output logic                            alarme,
    output logic [$clog2(N_SENSORES+1)-1:0] contagem,
    output logic [N_SENSORES-1:0]           memoria
);
    localparam int CW = $clog2(N_SENSORES + 1);
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int TW = (ATRASO_ENTRADA > 1) ? $clog2(ATRASO_ENTRADA) : 1;

    typedef enum logic [1:0] {DESARMADO, ARMADO, ENTRADA, DISPARADO} estado_t;

    estado_t               estado;
    logic [N_SENSORES-1:0] filt;
    logic [DW-1:0]         cnt [N_SENSORES];
    logic [TW-1:0]         timer;
    logic [CW-1:0]         soma;
    logic                  voto;

    always_comb begin
        soma = '0;
        for (int i = 0; i < N_SENSORES; i++) soma = soma + CW'(filt[i]);
    end

    assign voto       = contagem >= CW'(LIMIAR);
    assign armado     = estado != DESARMADO;
    assign pre_alarme = estado == ENTRADA;
    assign alarme     = estado == DISPARADO;

    // A filtered bit flips on the DEBOUNCE-th consecutive disagreeing sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= '0;
            for (int i = 0; i < N_SENSORES; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_SENSORES; i++) begin
                if (sensores[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DW'(DEBOUNCE - 1)) begin
                    filt[i] <= ~filt[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado   <= DESARMADO;
            timer    <= '0;
            memoria  <= '0;
            contagem <= '0;
        end else begin
            contagem <= soma;
            // Accumulate every sensor seen while the alarm sequence is running.
            if (estado == ENTRADA || estado == DISPARADO) memoria <= memoria | filt;
            if (desarmar) begin
                estado <= DESARMADO;
            end else begin
                case (estado)
                    DESARMADO: if (armar && !voto) begin
                        estado  <= ARMADO;
                        memoria <= '0;
                    end
                    ARMADO: if (voto) begin
                        memoria <= filt;
                        if (ATRASO_ENTRADA == 0) begin
                            estado <= DISPARADO;
                        end else begin
                            estado <= ENTRADA;
                            timer  <= TW'(ATRASO_ENTRADA - 1);
                        end
                    end
                    ENTRADA: if (timer == '0) estado <= DISPARADO;
                             else timer <= timer - 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alarme_votacao_param.sv
// tb_alarme_votacao_param: directed self-checking bench for alarme_votacao_param
module tb_alarme_votacao_param;
    logic       clk = 0;
    logic       rst;
    logic [2:0] sensores;
    logic       armar;
    logic       desarmar;
    logic       armado;
    logic       pre_alarme;
    logic       alarme;
    logic [1:0] contagem;
    logic [2:0] memoria;
    int         errors = 0;
    int         checks = 0;
    logic       visto;

    alarme_votacao_param dut (
        .clk(clk), .rst(rst), .sensores(sensores), .armar(armar), .desarmar(desarmar),
        .armado(armado), .pre_alarme(pre_alarme), .alarme(alarme),
        .contagem(contagem), .memoria(memoria)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1; armar = 1'($urandom); desarmar = 1'($urandom); sensores = 3'($urandom);
        tick(); tick();
        verifica("rst_armado", armado, 0);
        verifica("rst_pre", pre_alarme, 0);
        verifica("rst_alarme", alarme, 0);
        verifica("rst_contagem", contagem, 0);
        verifica("rst_memoria", memoria, 0);
        rst = 0; armar = 0; desarmar = 0; sensores = 3'b000;
        tick();

        // glitch rejection
        armar = 1; tick(); armar = 0;
        verifica("arm_ok", armado, 1);
        visto = 0;
        sensores = 3'b011;
        for (int i = 0; i < 3; i++) begin tick(); visto |= pre_alarme | (contagem != 0); end
        sensores = 3'b000;
        for (int i = 0; i < 10; i++) begin tick(); visto |= pre_alarme | (contagem != 0); end
        verifica("glitch", visto, 0);

        // full trigger
        sensores = 3'b011;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 4)  verifica("cont_e4", contagem, 0);
            if (e == 5)  verifica("cont_e5", contagem, 2);
            if (e == 5)  verifica("pre_e5", pre_alarme, 0);
            if (e == 6)  verifica("pre_e6", pre_alarme, 1);
            if (e == 13) verifica("alarme_e13", alarme, 0);
            if (e == 14) verifica("alarme_e14", alarme, 1);
            if (e == 14) verifica("pre_e14", pre_alarme, 0);
        end
        verifica("mem_trigger", memoria, 3'b011);
        sensores = 3'b000;
        for (int i = 0; i < 10; i++) tick();
        verifica("alarme_latched", alarme, 1);
        verifica("cont_drop", contagem, 0);
        desarmar = 1; tick(); desarmar = 0;
        verifica("dis_alarme", alarme, 0);
        verifica("dis_armado", armado, 0);
        verifica("mem_after_dis", memoria, 3'b011);

        // abort during entry delay
        armar = 1; tick(); armar = 0;
        verifica("rearm", armado, 1);
        verifica("mem_clear", memoria, 0);
        sensores = 3'b011;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 6) verifica("abort_pre", pre_alarme, 1);
        end
        desarmar = 1; tick(); desarmar = 0;
        verifica("abort_armado", armado, 0);
        verifica("abort_pre_off", pre_alarme, 0);
        sensores = 3'b000;
        visto = 0;
        for (int i = 0; i < 12; i++) begin tick(); visto |= alarme; end
        verifica("abort_no_alarme", visto, 0);
        verifica("abort_mem", memoria, 3'b011);
        armar = 1; desarmar = 1; tick(); armar = 0; desarmar = 0;
        verifica("both_req", armado, 0);

        // threshold and refusal
        armar = 1; tick(); armar = 0;
        verifica("arm3", armado, 1);
        sensores = 3'b100;
        visto = 0;
        for (int i = 0; i < 20; i++) begin tick(); visto |= pre_alarme | alarme; end
        verifica("one_sensor_cont", contagem, 1);
        verifica("one_sensor_no_trig", visto, 0);
        desarmar = 1; tick(); desarmar = 0;
        sensores = 3'b110;
        for (int i = 0; i < 6; i++) tick();
        verifica("cont_110", contagem, 2);
        armar = 1; tick(); armar = 0;
        verifica("refuse", armado, 0);
        verifica("refuse_mem", memoria, 0);

        // reset mid-alarm
        sensores = 3'b000;
        for (int i = 0; i < 6; i++) tick();
        armar = 1; tick(); armar = 0;
        sensores = 3'b110;
        for (int i = 0; i < 14; i++) tick();
        verifica("alarme_110", alarme, 1);
        verifica("mem_110", memoria, 3'b110);
        rst = 1; armar = 1; sensores = 3'b111; tick();
        verifica("mid_rst_armado", armado, 0);
        verifica("mid_rst_alarme", alarme, 0);
        verifica("mid_rst_cont", contagem, 0);
        verifica("mid_rst_mem", memoria, 0);
        rst = 0; armar = 0; sensores = 3'b000; tick();
        armar = 1; tick(); armar = 0;
        verifica("rearm_after_rst", armado, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
